// File: rtl/fmul_operand_packer_5_3.sv
// Joins two IEEE-style 9-bit operand streams into FloPoCo 11-bit X/Y pairs,
// buffered in a 2-entry FIFO, with a saturating count of flushed subnormals.
module fmul_operand_packer_5_3 #(
  parameter int unsigned FLUSH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [8:0]             a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [8:0]             b_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [10:0]            out_x,
  output logic [10:0]            out_y,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  localparam int unsigned SUM_W = FLUSH_CNT_W + 2;
  localparam logic [SUM_W-1:0] FLUSH_MAX = {2'b00, {FLUSH_CNT_W{1'b1}}};

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } pair_t;

  // IEEE-style {sign, exp, frac} to FloPoCo {exc, sign, exp, frac}; subnormals flush to zero
  function automatic logic [10:0] to_flopoco(input logic [8:0] d);
    logic [10:0] r;
    r = {2'b00, d[8], 8'h00};
    if (d[7:3] == 5'd31)
      r = {(d[2:0] == 3'd0) ? 2'b10 : 2'b11, d[8], 8'h00};
    else if (d[7:3] != 5'd0)
      r = {2'b01, d};
    return r;
  endfunction

  pair_t          mem [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     count;
  logic           space;
  logic           push;
  logic           pop;
  logic           a_sub;
  logic           b_sub;
  logic [SUM_W-1:0] flush_sum;
  logic [1:0]     count_nxt;

  // Join: both operands are consumed together or not at all
  assign space   = (count != 2'd2);
  assign a_ready = space & b_valid;
  assign b_ready = space & a_valid;
  assign push    = a_valid & b_valid & space;
  assign pop     = out_valid & out_ready;

  assign out_valid = (count != 2'd0);
  assign out_x     = mem[rd_ptr].x;
  assign out_y     = mem[rd_ptr].y;

  assign a_sub = (a_data[7:3] == 5'd0) && (a_data[2:0] != 3'd0);
  assign b_sub = (b_data[7:3] == 5'd0) && (b_data[2:0] != 3'd0);

  // Wide enough to hold an overshoot of 2 before saturation
  assign flush_sum = {2'b00, flush_cnt} + SUM_W'(a_sub) + SUM_W'(b_sub);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      flush_cnt <= '0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      count <= count_nxt;
      if (push) begin
        mem[wr_ptr] <= '{x: to_flopoco(a_data), y: to_flopoco(b_data)};
        wr_ptr      <= ~wr_ptr;
        flush_cnt   <= (flush_sum > FLUSH_MAX) ? FLUSH_MAX[FLUSH_CNT_W-1:0]
                                               : flush_sum[FLUSH_CNT_W-1:0];
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_fmul_operand_packer_5_3.sv
// Directed and streaming checks for fmul_operand_packer_5_3, including a
// FLUSH_CNT_W=2 instance sharing the same stimulus for saturation.
module tb_fmul_operand_packer_5_3;

  logic        clk;
  logic        rst_n;
  logic        a_valid, b_valid, out_ready;
  logic [8:0]  a_data, b_data;
  logic        a_ready, b_ready, out_valid;
  logic [10:0] out_x, out_y;
  logic [7:0]  flush_cnt;
  logic        s_a_ready, s_b_ready, s_out_valid;
  logic [10:0] s_out_x, s_out_y;
  logic [1:0]  s_flush_cnt;

  int checks = 0;
  int failures = 0;

  fmul_operand_packer_5_3 #(.FLUSH_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .flush_cnt(flush_cnt)
  );

  fmul_operand_packer_5_3 #(.FLUSH_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(s_a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(s_b_ready), .b_data(b_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_x(s_out_x), .out_y(s_out_y), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] conv(input logic [8:0] d);
    if (d[7:3] == 5'd0)  return {2'b00, d[8], 8'h00};
    if (d[7:3] == 5'd31) return {(d[2:0] == 3'd0) ? 2'b10 : 2'b11, d[8], 8'h00};
    return {2'b01, d};
  endfunction

  function automatic logic [8:0] rand_op();
    int unsigned sel;
    logic [4:0] e;
    sel = $urandom_range(0, 7);
    if (sel == 0)      e = 5'd0;
    else if (sel == 1) e = 5'd31;
    else               e = 5'($urandom_range(1, 30));
    return {1'($urandom_range(0, 1)), e, 3'($urandom_range(0, 7))};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [8:0] a, input logic [8:0] b);
    a_data = a; b_data = b; a_valid = 1'b1; b_valid = 1'b1;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  logic [8:0]  ra, rb;
  logic [21:0] exp_q[$];
  logic [21:0] exp_pair;
  int          exp_flush;

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_xy", 32'({out_x, out_y}), 32'd0);
    check("rst_flush", 32'(flush_cnt), 32'd0);
    check("rst_readys", 32'({a_ready, b_ready}), 32'd0);
    #3 rst_n = 1'b1;
    tick();

    // Normal pair
    out_ready = 1'b1;
    a_data = 9'h078; b_data = 9'h17C; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("norm_readys", 32'({a_ready, b_ready}), 32'd3);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("norm_valid", 32'(out_valid), 32'd1);
    check("norm_x", 32'(out_x), 32'h278);
    check("norm_y", 32'(out_y), 32'h37C);
    check("norm_flush", 32'(flush_cnt), 32'd0);
    tick();
    check("norm_drained", 32'(out_valid), 32'd0);

    // Specials
    push_one(9'h0F8, 9'h1F9);
    check("inf_x", 32'(out_x), 32'h400);
    check("nan_y", 32'(out_y), 32'h700);
    tick();
    push_one(9'h003, 9'h100);
    check("sub_x", 32'(out_x), 32'h000);
    check("negzero_y", 32'(out_y), 32'h100);
    check("sub_flush", 32'(flush_cnt), 32'd1);
    check("sub_valid", 32'(out_valid), 32'd1);
    tick();

    // Join: lone A is never accepted
    a_data = 9'h080; b_data = 9'h088; a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("join_a_ready", 32'(a_ready), 32'd0);
      tick();
      check("join_no_push", 32'(out_valid), 32'd0);
    end
    b_valid = 1'b1;
    #1;
    check("join_readys", 32'({a_ready, b_ready}), 32'd3);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("join_push", 32'(out_valid), 32'd1);
    check("join_x", 32'(out_x), 32'h280);
    tick();
    check("join_one_push", 32'(out_valid), 32'd0);

    // Backpressure / full
    out_ready = 1'b0;
    push_one(9'h080, 9'h041);
    push_one(9'h1C7, 9'h0F8);
    a_data = 9'h000; b_data = 9'h1FF; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("full_readys", 32'({a_ready, b_ready}), 32'd0);
    check("full_head", 32'({out_x, out_y}), 32'({11'h280, 11'h241}));
    tick();
    check("full_hold", 32'({out_x, out_y}), 32'({11'h280, 11'h241}));
    out_ready = 1'b1;
    #1;
    check("full_pop_readys", 32'({a_ready, b_ready}), 32'd0);
    tick();
    check("bp_p1", 32'({out_x, out_y}), 32'({11'h3C7, 11'h400}));
    check("bp_readys_back", 32'({a_ready, b_ready}), 32'd3);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    check("bp_p2", 32'({out_x, out_y}), 32'({11'h000, 11'h700}));
    check("bp_p2_valid", 32'(out_valid), 32'd1);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Streaming 100 random pairs at full rate
    do_reset();
    exp_flush = 0;
    out_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      ra = rand_op(); rb = rand_op();
      a_data = ra; b_data = rb;
      exp_q.push_back({conv(ra), conv(rb)});
      if (ra[7:3] == 5'd0 && ra[2:0] != 3'd0) exp_flush++;
      if (rb[7:3] == 5'd0 && rb[2:0] != 3'd0) exp_flush++;
      tick();
      exp_pair = exp_q.pop_front();
      if (!out_valid) begin
        check("stream_valid", 32'(out_valid), 32'd1);
      end else begin
        checks++;
        if ({out_x, out_y} !== exp_pair) begin
          failures++;
          $display("FAIL stream_pair[%0d]: got 0x%0h expected 0x%0h", i, {out_x, out_y}, exp_pair);
        end
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("stream_flush", 32'(flush_cnt), 32'(exp_flush));
    tick();
    check("stream_end", 32'(out_valid), 32'd0);

    // Saturation on the 2-bit counter
    do_reset();
    check("sat_start", 32'(s_flush_cnt), 32'd0);
    push_one(9'h001, 9'h107);
    check("sat_2", 32'(s_flush_cnt), 32'd2);
    check("wide_2", 32'(flush_cnt), 32'd2);
    push_one(9'h102, 9'h004);
    check("sat_3", 32'(s_flush_cnt), 32'd3);
    check("wide_4", 32'(flush_cnt), 32'd4);
    push_one(9'h005, 9'h006);
    check("sat_hold", 32'(s_flush_cnt), 32'd3);
    check("wide_6", 32'(flush_cnt), 32'd6);
    tick();

    // Async reset while full
    out_ready = 1'b0;
    push_one(9'h080, 9'h088);
    push_one(9'h090, 9'h098);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check("pre_rst_full", 32'({a_ready, b_ready}), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_flush", 32'(flush_cnt), 32'd0);
    check("arst_sat_flush", 32'(s_flush_cnt), 32'd0);
    check("arst_sat_valid", 32'(s_out_valid), 32'd0);
    check("arst_xy", 32'({out_x, out_y, s_out_x[0], s_out_y[0]}), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_no_beat", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_no_beat2", 32'({out_valid, s_a_ready, s_b_ready}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
